// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle MIPS main control FSM and its datapath.
// master = control FSM side, slave = datapath / memory side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
           mem_timeout, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
           mem_timeout, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath, with memory-ready timeout.
// Define MC_PERF_CNT_EN to add retired_cnt / cycle_cnt performance counters.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned WAIT_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MC_PERF_CNT_EN
  output logic [31:0]          retired_cnt,
  output logic [31:0]          cycle_cnt,
`endif
  multicycle_control_if.master ctrl_io
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ctl_t;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  is_mem, illegal, timeout;
  ctl_t                  ctl, ctl_out;

  assign is_mem = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    illegal = 1'b0;
    timeout = 1'b0;
    case (state_q)
      StFetch:  if (ctrl_io.mem_ready) state_d = StDecode;
      StDecode: begin
        case (ctrl_io.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: state_d = (ctrl_io.opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (ctrl_io.mem_ready) state_d = StMemWb;
      StMemWr:  if (ctrl_io.mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
    // Completion wins over timeout: only abort while ready is still low.
    if (is_mem && !ctrl_io.mem_ready && (cnt_q == WAIT_CNT_W'(MEM_TIMEOUT))) begin
      timeout = 1'b1;
      state_d = StFetch;
    end
    if (timeout || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (is_mem && !ctrl_io.mem_ready) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      StFetch: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        if (ctrl_io.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
        end
      end
      StDecode: ctl.alu_src_b = 2'b11;
      StMemAdr, StAddiEx: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      StMemRd: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      StExec: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
      end
      StAluWb: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
      end
      StJump: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b10;
      end
      StAddiWb: ctl.reg_write = 1'b1;
      default: ;
    endcase
    ctl.illegal_op  = illegal;
    ctl.mem_timeout = timeout;
    ctl_out = rst_n ? ctl : '0;
  end

  assign ctrl_io.pc_write      = ctl_out.pc_write;
  assign ctrl_io.pc_write_cond = ctl_out.pc_write_cond;
  assign ctrl_io.i_or_d        = ctl_out.i_or_d;
  assign ctrl_io.mem_read      = ctl_out.mem_read;
  assign ctrl_io.mem_write     = ctl_out.mem_write;
  assign ctrl_io.ir_write      = ctl_out.ir_write;
  assign ctrl_io.mem_to_reg    = ctl_out.mem_to_reg;
  assign ctrl_io.reg_dst       = ctl_out.reg_dst;
  assign ctrl_io.reg_write     = ctl_out.reg_write;
  assign ctrl_io.alu_src_a     = ctl_out.alu_src_a;
  assign ctrl_io.alu_src_b     = ctl_out.alu_src_b;
  assign ctrl_io.alu_op        = ctl_out.alu_op;
  assign ctrl_io.pc_source     = ctl_out.pc_source;
  assign ctrl_io.illegal_op    = ctl_out.illegal_op;
  assign ctrl_io.mem_timeout   = ctl_out.mem_timeout;
  assign ctrl_io.state_o       = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] retired_q, cycle_q;
  logic        retire;

  assign retire = (state_d == StFetch) && !timeout &&
                  ((state_q == StMemWb) || (state_q == StMemWr) || (state_q == StAluWb) ||
                   (state_q == StBranch) || (state_q == StJump) || (state_q == StAddiWb));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: state sequences, control words,
// wait/timeout behaviour and mid-instruction reset.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_if bus ();
`ifdef MC_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif

  multicycle_control #(
    .MEM_TIMEOUT(15),
    .WAIT_CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MC_PERF_CNT_EN
    .retired_cnt(retired_cnt),
    .cycle_cnt  (cycle_cnt),
`endif
    .ctrl_io    (bus)
  );

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
  //  reg_write, alu_src_a}_{alu_src_b}_{alu_op}_{pc_source}_{illegal_op, mem_timeout}
  logic [17:0] ctl;
  assign ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op, bus.mem_timeout};

  localparam logic [17:0] C_ZERO = 18'b0000000000_00_00_00_00;
  localparam logic [17:0] C_FRDY = 18'b1001010000_01_00_00_00;
  localparam logic [17:0] C_FNRD = 18'b0001000000_01_00_00_00;
  localparam logic [17:0] C_DEC  = 18'b0000000000_11_00_00_00;
  localparam logic [17:0] C_DILL = 18'b0000000000_11_00_00_10;
  localparam logic [17:0] C_MADR = 18'b0000000001_10_00_00_00;
  localparam logic [17:0] C_MRD  = 18'b0011000000_00_00_00_00;
  localparam logic [17:0] C_MWB  = 18'b0000001010_00_00_00_00;
  localparam logic [17:0] C_MWR  = 18'b0010100000_00_00_00_00;
  localparam logic [17:0] C_EXEC = 18'b0000000001_00_10_00_00;
  localparam logic [17:0] C_AWB  = 18'b0000000110_00_00_00_00;
  localparam logic [17:0] C_BR   = 18'b0100000001_00_01_01_00;
  localparam logic [17:0] C_JMP  = 18'b1000000000_00_00_10_00;
  localparam logic [17:0] C_IWB  = 18'b0000000010_00_00_00_00;
  localparam logic [17:0] C_TO   = 18'b0000000000_00_00_00_01;

  // Drive-only cycle advance; no checking here.
  task automatic cyc(input logic rdy);
    bus.mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_R;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (ctl !== C_ZERO) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got %b want %b", i, ctl, C_ZERO);
      end
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.state_o !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d want 0", bus.state_o);
    end
    n_cmp++;
    if (ctl !== C_FRDY) begin
      n_err++;
      $display("FAIL reset_fetch_ctl: got %b want %b", ctl, C_FRDY);
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [3:0]  st [5];
    logic        rd [5];
    logic [17:0] cv [5];
    st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cv = '{C_FRDY, C_DEC, C_EXEC, C_AWB, C_FNRD};
    bus.opcode = OP_R;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rd[i];
      #1;
      n_cmp++;
      if (bus.state_o !== st[i]) begin
        n_err++;
        $display("FAIL rtype_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]);
      end
      n_cmp++;
      if (ctl !== cv[i]) begin
        n_err++;
        $display("FAIL rtype_ctl[%0d]: got %b want %b", i, ctl, cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [9];
    logic        rd [9];
    logic [17:0] cv [9];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    cv = '{C_FRDY, C_DEC, C_MADR, C_MRD, C_MRD, C_MRD, C_MRD, C_MWB, C_FNRD};
    bus.opcode = OP_LW;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = rd[i];
      #1;
      n_cmp++;
      if (bus.state_o !== st[i]) begin
        n_err++;
        $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]);
      end
      n_cmp++;
      if (ctl !== cv[i]) begin
        n_err++;
        $display("FAIL lw_ctl[%0d]: got %b want %b", i, ctl, cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_jump();
    logic [3:0]  st [7];
    logic [5:0]  op [7];
    logic        rd [7];
    logic [17:0] cv [7];
    st = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0};
    op = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J, OP_J};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cv = '{C_FRDY, C_DEC, C_BR, C_FRDY, C_DEC, C_JMP, C_FNRD};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = op[i];
      bus.mem_ready = rd[i];
      #1;
      n_cmp++;
      if (bus.state_o !== st[i]) begin
        n_err++;
        $display("FAIL brj_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]);
      end
      n_cmp++;
      if (ctl !== cv[i]) begin
        n_err++;
        $display("FAIL brj_ctl[%0d]: got %b want %b", i, ctl, cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [3];
    logic        rd [3];
    logic [17:0] cv [3];
    st = '{4'd0, 4'd1, 4'd0};
    rd = '{1'b1, 1'b1, 1'b0};
    cv = '{C_FRDY, C_DILL, C_FNRD};
    bus.opcode = OP_BAD;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = rd[i];
      #1;
      n_cmp++;
      if (bus.state_o !== st[i]) begin
        n_err++;
        $display("FAIL illegal_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]);
      end
      n_cmp++;
      if (ctl !== cv[i]) begin
        n_err++;
        $display("FAIL illegal_ctl[%0d]: got %b want %b", i, ctl, cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  st [9];
    logic [5:0]  op [9];
    logic [17:0] cv [9];
    st = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    op = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
    cv = '{C_FRDY, C_DEC, C_MADR, C_IWB, C_FRDY, C_DEC, C_MADR, C_MWR, C_FNRD};
    for (int i = 0; i < 9; i++) begin
      bus.opcode = op[i];
      bus.mem_ready = (i != 8);
      #1;
      n_cmp++;
      if (bus.state_o !== st[i]) begin
        n_err++;
        $display("FAIL b2b_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]);
      end
      n_cmp++;
      if (ctl !== cv[i]) begin
        n_err++;
        $display("FAIL b2b_ctl[%0d]: got %b want %b", i, ctl, cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    // sw with ready stuck low: pulse on the 16th MEMWR cycle (after 15 waits).
    bus.opcode = OP_SW;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    for (int i = 0; i < 16; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      n_cmp++;
      if (bus.state_o !== 4'd5 || ctl !== ((i == 15) ? (C_MWR | C_TO) : C_MWR)) begin
        n_err++;
        $display("FAIL sw_timeout[%0d]: got state %0d ctl %b want state 5 ctl %b", i,
                 bus.state_o, ctl, (i == 15) ? (C_MWR | C_TO) : C_MWR);
      end
      @(negedge clk);
    end
    // Refetch timeout: counter restarts on re-entry to FETCH.
    for (int i = 0; i < 17; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      n_cmp++;
      if (bus.state_o !== 4'd0 || ctl !== ((i == 15) ? (C_FNRD | C_TO) : C_FNRD)) begin
        n_err++;
        $display("FAIL fetch_timeout[%0d]: got state %0d ctl %b want state 0 ctl %b", i,
                 bus.state_o, ctl, (i == 15) ? (C_FNRD | C_TO) : C_FNRD);
      end
      @(negedge clk);
    end
    // lw: ready arrives on the would-be timeout cycle, completion wins.
    bus.opcode = OP_LW;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    for (int i = 0; i < 16; i++) begin
      bus.mem_ready = (i == 15);
      #1;
      n_cmp++;
      if (bus.state_o !== 4'd3 || ctl !== C_MRD) begin
        n_err++;
        $display("FAIL lw_ready_wins[%0d]: got state %0d ctl %b want state 3 ctl %b", i,
                 bus.state_o, ctl, C_MRD);
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus.state_o !== 4'd4 || ctl !== C_MWB) begin
      n_err++;
      $display("FAIL lw_ready_wins_wb: got state %0d ctl %b want state 4 ctl %b",
               bus.state_o, ctl, C_MWB);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.opcode = OP_SW;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.state_o !== 4'd5 || ctl !== C_ZERO) begin
      n_err++;
      $display("FAIL midrst_hold: got state %0d ctl %b want state 5 ctl %b",
               bus.state_o, ctl, C_ZERO);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.state_o !== 4'd0 || ctl !== C_ZERO) begin
      n_err++;
      $display("FAIL midrst_fetch: got state %0d ctl %b want state 0 ctl %b",
               bus.state_o, ctl, C_ZERO);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.state_o !== 4'd0 || ctl !== C_FNRD) begin
      n_err++;
      $display("FAIL midrst_release: got state %0d ctl %b want state 0 ctl %b",
               bus.state_o, ctl, C_FNRD);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.opcode = OP_R;
    bus.mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
